l2_bus_responder: RTL and testbench

//  Responder end of the L2 cache's bus operations (READ, WRITE, RFO, INVALIDATE).

---
 rtl/l2_bus_responder_if.sv | 34 +++
 rtl/l2_bus_responder.sv | 124 ++++++++++++
 tb/tb_l2_bus_responder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_bus_responder_if.sv
// Bus bundle between the L2 request source / snoop fabric and the bus responder.
// Latency: none, wires only.
// Backpressure: req_ready from the responder holds off new requests while busy.
interface l2_bus_responder_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic              snoop_valid;
   logic [1:0]        snoop_op;
   logic [ADDR_W-1:0] snoop_addr;
   logic [1:0]        snoop_resp;
   logic              snoop_wb_done;
   logic              rsp_valid;
   logic [1:0]        rsp_snoop;
   logic              rsp_err;
   logic [7:0]        hitm_cnt;

   // responder side
   modport slave (
      input  req_valid, req_op, req_addr, snoop_resp, snoop_wb_done,
      output req_ready, snoop_valid, snoop_op, snoop_addr,
             rsp_valid, rsp_snoop, rsp_err, hitm_cnt
   );

   // requester / fabric side
   modport master (
      output req_valid, req_op, req_addr, snoop_resp, snoop_wb_done,
      input  req_ready, snoop_valid, snoop_op, snoop_addr,
             rsp_valid, rsp_snoop, rsp_err, hitm_cnt
   );
endinterface

// File: rtl/l2_bus_responder.sv
// L2 bus responder: snoop broadcast, response merge, HITM write-back wait, memory latency model.
// Latency: WRITE 1+MEM_LAT, READ/RFO 2+SNOOP_WIN+MEM_LAT, INVALIDATE 2+SNOOP_WIN (+write-back wait on HITM).
// Backpressure: one transaction in flight; req_ready is high only while idle.
module l2_bus_responder #(
   parameter int ADDR_W       = 32,
   parameter int LINE_OFF     = 6,
   parameter int SNOOP_WIN    = 2,
   parameter int MEM_LAT      = 4,
   parameter int HITM_TIMEOUT = 16
) (
   input logic              clk,
   input logic              rst,
   l2_bus_responder_if.slave bus
);

   localparam int MAX_A = (SNOOP_WIN > MEM_LAT) ? SNOOP_WIN : MEM_LAT;
   localparam int MAX_P = (MAX_A > HITM_TIMEOUT) ? MAX_A : HITM_TIMEOUT;
   localparam int CNT_W = $clog2(MAX_P) + 1;

   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_INV   = 2'b11;
   localparam logic [1:0] SN_NOHIT = 2'b00;
   localparam logic [1:0] SN_HITM  = 2'b10;

   localparam logic [ADDR_W-1:0] LINE_MASK =
      ~ADDR_W'((64'd1 << LINE_OFF) - 64'd1);

   localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(SNOOP_WIN - 1);
   localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_LAT - 1);
   localparam logic [CNT_W-1:0] WB_LIMIT = CNT_W'(HITM_TIMEOUT);

   typedef enum logic [2:0] {
      IDLE, SNOOP_ISSUE, SNOOP_WAIT, WAIT_WB, MEM, RESP
   } state_t;

   state_t           state, state_nxt;
   logic [1:0]       op_q;
   logic [1:0]       merged_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       samp;
   logic [1:0]       merged_now;
   logic             accept;
   logic             wb_expired;

   assign bus.req_ready   = (state == IDLE);
   assign bus.snoop_valid = (state == SNOOP_ISSUE);
   assign bus.rsp_valid   = (state == RESP);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic and snoop merge; reserved 11 is treated as HITM so NOHIT<HIT<HITM compares numerically
   always_comb begin
      samp       = (bus.snoop_resp == 2'b11) ? SN_HITM : bus.snoop_resp;
      merged_now = merged_q;
      if (state == SNOOP_WAIT && samp > merged_q) merged_now = samp;
      accept     = bus.req_valid && (state == IDLE);
      // the timer holds the number of cycles already spent in WAIT_WB; a write-back in the expiry cycle still wins
      wb_expired = (state == WAIT_WB) && !bus.snoop_wb_done && (cnt_q == WB_LIMIT);
      state_nxt  = state;
      case (state)
         IDLE:        if (accept) state_nxt = (bus.req_op == OP_WRITE) ? MEM : SNOOP_ISSUE;
         SNOOP_ISSUE: state_nxt = SNOOP_WAIT;
         SNOOP_WAIT:  if (cnt_q == '0) begin
                         if (merged_now == SN_HITM) state_nxt = WAIT_WB;
                         else if (op_q == OP_INV)   state_nxt = RESP;
                         else                       state_nxt = MEM;
                      end
         WAIT_WB:     if (bus.snoop_wb_done)  state_nxt = (op_q == OP_INV) ? RESP : MEM;
                      else if (wb_expired)    state_nxt = RESP;
         MEM:         if (cnt_q == '0) state_nxt = RESP;
         RESP:        state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
   end

   // datapath: request latch, shared phase counter, merge register, completion fields, HITM counter
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q           <= '0;
         merged_q       <= SN_NOHIT;
         cnt_q          <= '0;
         bus.snoop_op   <= '0;
         bus.snoop_addr <= '0;
         bus.rsp_snoop  <= SN_NOHIT;
         bus.rsp_err    <= 1'b0;
         bus.hitm_cnt   <= '0;
      end else begin
         if (accept) begin
            op_q           <= bus.req_op;
            bus.snoop_op   <= bus.req_op;
            bus.snoop_addr <= bus.req_addr & LINE_MASK;
            merged_q       <= SN_NOHIT;
         end else if (state == SNOOP_WAIT) begin
            merged_q <= merged_now;
         end

         if (state_nxt != state) begin
            case (state_nxt)
               SNOOP_WAIT: cnt_q <= WIN_LOAD;
               WAIT_WB:    cnt_q <= '0;
               MEM:        cnt_q <= MEM_LOAD;
               default:    cnt_q <= cnt_q;
            endcase
         end else if (state == SNOOP_WAIT || state == MEM) begin
            cnt_q <= cnt_q - 1'b1;
         end else if (state == WAIT_WB) begin
            cnt_q <= cnt_q + 1'b1;
         end

         if (state == SNOOP_WAIT && state_nxt == WAIT_WB && bus.hitm_cnt != 8'hFF)
            bus.hitm_cnt <= bus.hitm_cnt + 8'd1;

         if (state_nxt == RESP && state != RESP) begin
            bus.rsp_snoop <= merged_now;
            bus.rsp_err   <= wb_expired;
         end
      end
   end

endmodule

// File: tb/tb_l2_bus_responder.sv
// Directed-vector bench for l2_bus_responder with queue scoreboards for completions and snoop strobes.
module tb_l2_bus_responder;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;

   l2_bus_responder_if #(.ADDR_W(32)) bus ();

   l2_bus_responder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int         cyc;
      logic [1:0] snp;
      logic       err;
   } rsp_exp_t;

   typedef struct {
      int          cyc;
      logic [1:0]  op;
      logic [31:0] addr;
   } snp_exp_t;

   rsp_exp_t rsp_q[$];
   snp_exp_t snp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // completion monitor
   always @(negedge clk) begin
      if (!rst && bus.rsp_valid === 1'b1) begin
         if (rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: rsp_valid at cycle %0d with no pending transaction", cyc);
         end else begin
            rsp_exp_t e;
            e = rsp_q.pop_front();
            chk("rsp_cycle", cyc, e.cyc);
            chk("rsp_snoop", {30'd0, bus.rsp_snoop}, {30'd0, e.snp});
            chk("rsp_err",   {31'd0, bus.rsp_err},   {31'd0, e.err});
         end
      end
   end

   // snoop broadcast monitor
   always @(negedge clk) begin
      if (!rst && bus.snoop_valid === 1'b1) begin
         if (snp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL snoop_unexpected: snoop_valid at cycle %0d with no snooping transaction", cyc);
         end else begin
            snp_exp_t e;
            e = snp_q.pop_front();
            chk("snoop_cycle", cyc, e.cyc);
            chk("snoop_op",   {30'd0, bus.snoop_op}, {30'd0, e.op});
            chk("snoop_addr", bus.snoop_addr, e.addr);
         end
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, ".req_ready"},   {31'd0, bus.req_ready},   32'd1);
      chk({tag, ".snoop_valid"}, {31'd0, bus.snoop_valid}, 32'd0);
      chk({tag, ".snoop_op"},    {30'd0, bus.snoop_op},    32'd0);
      chk({tag, ".snoop_addr"},  bus.snoop_addr,           32'd0);
      chk({tag, ".rsp_valid"},   {31'd0, bus.rsp_valid},   32'd0);
      chk({tag, ".rsp_snoop"},   {30'd0, bus.rsp_snoop},   32'd0);
      chk({tag, ".rsp_err"},     {31'd0, bus.rsp_err},     32'd0);
      chk({tag, ".hitm_cnt"},    {24'd0, bus.hitm_cnt},    32'd0);
   endtask

   // waits (bounded) at negedges for req_ready; returns the accept cycle
   task automatic wait_accept(input string tag, output int t);
      int to;
      to = 0;
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && to < 100) begin
         @(negedge clk);
         to++;
      end
      if (bus.req_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s.accept_timeout: req_ready=%0b expected 1 within 100 cycles", tag, bus.req_ready);
      end
      t = cyc;
   endtask

   // one snooping transaction: resp r2/r3 in the two window cycles, wb_done at offset wb_k (0 = none)
   task automatic txn(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] saddr,
                      input logic [1:0] r2, input logic [1:0] r3, input int wb_k,
                      input int lat, input logic [1:0] exp_snp, input logic exp_err);
      int t;
      rsp_exp_t re;
      snp_exp_t se;
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      wait_accept("txn", t);
      re.cyc = t + lat; re.snp = exp_snp; re.err = exp_err;
      rsp_q.push_back(re);
      se.cyc = t + 1; se.op = op; se.addr = saddr;
      snp_q.push_back(se);
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         bus.req_valid     = 1'b0;
         // out-of-window noise: reserved response during the broadcast cycle, stray wb_done in the window
         bus.snoop_resp    = (k == 1) ? 2'b11 : (k == 2) ? r2 : (k == 3) ? r3 : 2'b00;
         bus.snoop_wb_done = (k == wb_k) || (wb_k == 0 && k == 2);
      end
      @(posedge clk); #1;
      bus.snoop_resp    = 2'b00;
      bus.snoop_wb_done = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int t_w;
      int t_i;
      rsp_exp_t re;
      snp_exp_t se;

      cyc               = 0;
      checks            = 0;
      errors            = 0;
      rst               = 1'b1;
      bus.req_valid     = 1'b0;
      bus.req_op        = 2'b00;
      bus.req_addr      = '0;
      bus.snoop_resp    = 2'b00;
      bus.snoop_wb_done = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset("por");
      @(posedge clk); #1;
      rst = 1'b0;

      // READ NOHIT
      txn(2'b00, 32'h0000_12C7, 32'h0000_12C0, 2'b00, 2'b00, 0, 8, 2'b00, 1'b0);

      // RFO, HITM in the second window cycle, write-back at T+10
      txn(2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEC0, 2'b00, 2'b10, 10, 15, 2'b10, 1'b0);
      chk("hitm_cnt_rfo", {24'd0, bus.hitm_cnt}, 32'd1);

      // READ HITM without write-back: timeout
      txn(2'b00, 32'h0000_0040, 32'h0000_0040, 2'b10, 2'b00, 0, 21, 2'b10, 1'b1);
      chk("hitm_cnt_timeout", {24'd0, bus.hitm_cnt}, 32'd2);

      // READ HIT then reserved (HITM), write-back in the expiry cycle wins
      txn(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFC0, 2'b01, 2'b11, 20, 25, 2'b10, 1'b0);
      chk("hitm_cnt_tie", {24'd0, bus.hitm_cnt}, 32'd3);

      // WRITE followed by INVALIDATE held on req_valid while the WRITE is busy
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b01;
      bus.req_addr  = 32'h0000_1000;
      wait_accept("write", t_w);
      re.cyc = t_w + 5; re.snp = 2'b00; re.err = 1'b0;
      rsp_q.push_back(re);
      @(posedge clk); #1;
      bus.req_op   = 2'b11;
      bus.req_addr = 32'h1234_5678;
      wait_accept("inv", t_i);
      chk("inv_accept_cycle", t_i, t_w + 6);
      re.cyc = t_i + 4; re.snp = 2'b01; re.err = 1'b0;
      rsp_q.push_back(re);
      se.cyc = t_i + 1; se.op = 2'b11; se.addr = 32'h1234_5640;
      snp_q.push_back(se);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         bus.req_valid  = 1'b0;
         bus.snoop_resp = (k == 2) ? 2'b01 : 2'b00;
      end
      @(posedge clk); #1;
      bus.snoop_resp = 2'b00;
      chk("hitm_cnt_inv_hit", {24'd0, bus.hitm_cnt}, 32'd3);

      // reset for two cycles while a WRITE sits in MEM
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b01;
      bus.req_addr  = 32'hABCD_EF01;
      wait_accept("rst_write", t_w);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk_reset("rst_mid_mem");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_reset("rst_release");
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("rst_ready_idle", {31'd0, bus.req_ready}, 32'd1);

      // HITM counter saturation via quick INVALIDATE HITM transactions
      for (int i = 0; i < 260; i++) begin
         txn(2'b11, 32'h0000_0100 + i, 32'h0000_0100 + (i & 32'hFFFF_FFC0),
             2'b10, 2'b00, 4, 5, 2'b10, 1'b0);
         if (i == 0 || i == 253 || i == 254 || i == 255 || i == 259)
            chk("hitm_cnt_sat", {24'd0, bus.hitm_cnt}, (i + 1 > 255) ? 32'd255 : i + 1);
      end

      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rsp_queue_empty",   rsp_q.size(), 32'd0);
      chk("snoop_queue_empty", snp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
